// File: rtl/ohs_boost_pwm_gen_if.sv
// Duty-word stream from the digital controller into the boost PWM generator.
// A word moves on every rising aclk edge where duty_tvalid && duty_tready; tdata must hold while tvalid is high and tready is low.
interface ohs_boost_pwm_gen_if #(
  parameter int counter_width = 16
);
  logic [counter_width-1:0] duty_tdata;
  logic                     duty_tvalid;
  logic                     duty_tready;

  modport master (
    output duty_tdata,
    output duty_tvalid,
    input  duty_tready
  );

  modport slave (
    input  duty_tdata,
    input  duty_tvalid,
    output duty_tready
  );
endinterface

// File: rtl/ohs_boost_pwm_gen.sv
// Single-switch boost PWM with period-boundary duty shadowing and a free-running
// plant integrator strobe (ce) for the hardware-in-the-loop plant model.
module ohs_boost_pwm_gen #(
  parameter int counter_width = 16
) (
  input  logic                     aclk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [counter_width-1:0] period,
  input  logic [counter_width-1:0] ce_div,
  ohs_boost_pwm_gen_if.slave       duty_s,
  output logic                     S1_pwm,
  output logic                     sync,
  output logic                     ce,
  output logic [counter_width-1:0] duty_active
);

  localparam logic [counter_width-1:0] ONE  = {{(counter_width-1){1'b0}}, 1'b1};
  localparam logic [counter_width-1:0] ZERO = '0;

  logic [counter_width-1:0] r_cnt;
  logic [counter_width-1:0] r_period_active;
  logic [counter_width-1:0] r_duty_active;
  logic [counter_width-1:0] r_duty_shadow;
  logic [counter_width-1:0] r_presc;
  logic                     r_pending;
  logic                     r_s1;
  logic                     r_sync;
  logic                     r_ce;

  logic w_wrap;
  logic w_xfer;

  assign w_wrap = enable && (r_cnt == r_period_active);
  assign w_xfer = duty_s.duty_tvalid && !r_pending;

  assign duty_s.duty_tready = !r_pending;
  assign S1_pwm             = r_s1;
  assign sync               = r_sync;
  assign ce                 = r_ce;
  assign duty_active        = r_duty_active;

  // Carrier: held at 0 while disabled so re-enable restarts a full period.
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_cnt <= ZERO;
    end else if (!enable || w_wrap) begin
      r_cnt <= ZERO;
    end else begin
      r_cnt <= r_cnt + ONE;
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      r_s1   <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_s1   <= enable && (r_cnt < r_duty_active);
      r_sync <= enable && (r_cnt == ZERO);
    end
  end

  // A word taken mid-period waits in the shadow; one taken on the wrap edge goes straight in.
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_duty_active   <= ZERO;
      r_duty_shadow   <= ZERO;
      r_pending       <= 1'b0;
      r_period_active <= period;
    end else if (w_wrap) begin
      r_period_active <= period;
      if (r_pending) begin
        r_duty_active <= r_duty_shadow;
        r_pending     <= 1'b0;
      end else if (w_xfer) begin
        r_duty_active <= duty_s.duty_tdata;
      end
    end else if (w_xfer) begin
      r_duty_shadow <= duty_s.duty_tdata;
      r_pending     <= 1'b1;
    end
  end

  // Prescaler runs regardless of enable; an overshoot after a ce_div cut wraps silently.
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_presc <= ZERO;
      r_ce    <= 1'b0;
    end else begin
      r_ce <= (r_presc == ce_div);
      if (r_presc >= ce_div) begin
        r_presc <= ZERO;
      end else begin
        r_presc <= r_presc + ONE;
      end
    end
  end

endmodule

// File: tb/tb_ohs_boost_pwm_gen.sv
// Directed scenarios plus randomized traffic for ohs_boost_pwm_gen, checked against
// a cycle-level reference model and a duty-word scoreboard.
module tb_ohs_boost_pwm_gen;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic         aclk = 1'b0;
  logic         reset;
  logic         enable;
  logic [W-1:0] period;
  logic [W-1:0] ce_div;
  logic         S1_pwm;
  logic         sync;
  logic         ce;
  logic [W-1:0] duty_active;

  always #5 aclk = ~aclk;

  ohs_boost_pwm_gen_if #(.counter_width(W)) duty_if ();

  ohs_boost_pwm_gen #(.counter_width(W)) dut (
    .aclk        (aclk),
    .reset       (reset),
    .enable      (enable),
    .period      (period),
    .ce_div      (ce_div),
    .duty_s      (duty_if),
    .S1_pwm      (S1_pwm),
    .sync        (sync),
    .ce          (ce),
    .duty_active (duty_active)
  );

  // ---------------- counters ----------------
  int n_cmp = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  logic [W-1:0] m_cnt    = '0;
  logic [W-1:0] m_pa     = '0;
  logic [W-1:0] m_duty   = '0;
  logic [W-1:0] m_shadow = '0;
  logic [W-1:0] m_presc  = '0;
  logic         m_pend   = 1'b0;
  logic         m_s1     = 1'b0;
  logic         m_sync   = 1'b0;
  logic         m_ce     = 1'b0;
  logic         m_xfer   = 1'b0;
  logic         m_apply  = 1'b0;

  // scoreboard: duty words accepted, in order, awaiting their turn in duty_active
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_cmp++;
    n_err++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  // Applies one clock edge of the behaviour using the inputs that were present before it.
  task automatic model_step();
    logic wrap;
    logic xfer;
    m_xfer  = 1'b0;
    m_apply = 1'b0;
    if (reset) begin
      m_cnt = '0; m_duty = '0; m_shadow = '0; m_pend = 1'b0;
      m_s1 = 1'b0; m_sync = 1'b0; m_ce = 1'b0; m_presc = '0;
      m_pa = period;
      exp_q.delete();
    end else begin
      wrap   = enable && (m_cnt == m_pa);
      xfer   = duty_if.duty_tvalid && !m_pend;
      m_xfer = xfer;
      m_s1   = enable && (m_cnt < m_duty);
      m_sync = enable && (m_cnt == 0);
      m_ce   = (m_presc == ce_div);
      m_presc = (m_presc >= ce_div) ? '0 : m_presc + 1'b1;
      if (xfer) exp_q.push_back(duty_if.duty_tdata);
      if (wrap) begin
        m_pa = period;
        if (m_pend) begin
          m_duty = m_shadow; m_pend = 1'b0; m_apply = 1'b1;
        end else if (xfer) begin
          m_duty = duty_if.duty_tdata; m_apply = 1'b1;
        end
      end else if (xfer) begin
        m_shadow = duty_if.duty_tdata; m_pend = 1'b1;
      end
      m_cnt = (!enable || wrap) ? '0 : m_cnt + 1'b1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    logic [W-1:0] sb;
    @(posedge aclk);
    #1;
    model_step();
    chk("s1_pwm", S1_pwm, m_s1);
    chk("sync", sync, m_sync);
    chk("ce", ce, m_ce);
    chk("tready", duty_if.duty_tready, !m_pend);
    chk("duty_active", duty_active, m_duty);
    if (m_apply) begin
      if (exp_q.size() == 0) timeout("duty_sb_empty");
      else begin
        sb = exp_q.pop_front();
        chk("duty_sb", duty_active, sb);
      end
    end
  endtask

  task automatic send_duty(input logic [W-1:0] val);
    bit done = 1'b0;
    duty_if.duty_tvalid = 1'b1;
    duty_if.duty_tdata  = val;
    for (int i = 0; i < 100 && !done; i++) begin
      cycle();
      done = m_xfer;
    end
    duty_if.duty_tvalid = 1'b0;
    if (!done) timeout("send_duty");
  endtask

  task automatic wait_cnt(input logic [W-1:0] v);
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      cycle();
      done = (m_cnt == v);
    end
    if (!done) timeout("wait_cnt");
  endtask

  task automatic wait_sync();
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      cycle();
      done = m_sync;
    end
    if (!done) timeout("wait_sync");
  endtask

  // Counts DUT outputs over the current cycle plus the next n-1 cycles.
  task automatic count_outs(input int n, output int highs, output int syncs, output int ces);
    highs = int'(S1_pwm); syncs = int'(sync); ces = int'(ce);
    for (int i = 1; i < n; i++) begin
      cycle();
      highs += int'(S1_pwm); syncs += int'(sync); ces += int'(ce);
    end
  endtask

  // ---------------- stimulus ----------------
  int h, s, c;

  initial begin
    reset = 1'b1; enable = 1'b0; period = 16'd9; ce_div = 16'd4;
    duty_if.duty_tvalid = 1'b0; duty_if.duty_tdata = '0;
    cycle(); cycle();
    chk("rst_s1", S1_pwm, 1'b0);
    chk("rst_duty", duty_active, 16'd0);
    chk("rst_tready", duty_if.duty_tready, 1'b1);
    chk("rst_ce", ce, 1'b0);
    reset = 1'b0;

    // T1 steady state
    enable = 1'b1;
    send_duty(16'd3);
    wait_sync();
    count_outs(10, h, s, c);
    chk("t1_highs", h, 3);
    chk("t1_syncs", s, 1);
    wait_sync();
    chk("t1_sync_s1", S1_pwm, 1'b1);

    // T2 shadowing
    wait_cnt(16'd4);
    send_duty(16'd7);
    chk("t2_tready_low", duty_if.duty_tready, 1'b0);
    chk("t2_duty_old", duty_active, 16'd3);
    wait_sync();
    chk("t2_duty_new", duty_active, 16'd7);
    count_outs(10, h, s, c);
    chk("t2_highs", h, 7);

    // T3 limits
    send_duty(16'd0);
    wait_sync(); wait_sync();
    count_outs(10, h, s, c);
    chk("t3_zero_highs", h, 0);
    send_duty(16'd15);
    wait_sync(); wait_sync();
    count_outs(20, h, s, c);
    chk("t3_full_highs", h, 20);
    chk("t3_full_syncs", s, 2);

    // T4 backpressure then wrap bypass
    send_duty(16'd3);
    wait_sync(); wait_sync();
    wait_cnt(16'd2);
    send_duty(16'd5);
    chk("t4_stall", duty_if.duty_tready, 1'b0);
    send_duty(16'd6);
    chk("t4_second_after_wrap", duty_active, 16'd5);
    wait_sync();
    chk("t4_duty6", duty_active, 16'd6);
    wait_cnt(16'd9);
    send_duty(16'd8);
    chk("t4_bypass", duty_active, 16'd8);
    chk("t4_bypass_tready", duty_if.duty_tready, 1'b1);
    wait_sync();
    count_outs(10, h, s, c);
    chk("t4_bypass_highs", h, 8);

    // T5 ce strobe
    enable = 1'b0;
    cycle();
    count_outs(20, h, s, c);
    chk("t5_ce_div4", c, 4);
    chk("t5_disabled_s1", h, 0);
    ce_div = 16'd0;
    cycle(); cycle();
    count_outs(10, h, s, c);
    chk("t5_ce_div0", c, 10);
    ce_div = 16'd4;

    // T6 reset and enable
    enable = 1'b1;
    wait_sync();
    wait_cnt(16'd6);
    chk("t6_s1_before", S1_pwm, 1'b1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("t6_s1", S1_pwm, 1'b0);
    chk("t6_duty", duty_active, 16'd0);
    chk("t6_tready", duty_if.duty_tready, 1'b1);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t6_disabled_s1", S1_pwm, 1'b0);
    end
    enable = 1'b1;
    cycle();
    chk("t6_reenable_sync", sync, 1'b1);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      reset  = ($urandom_range(0, 99) == 0);
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) period = 16'($urandom_range(0, 9));
      if ($urandom_range(0, 29) == 0) ce_div = 16'($urandom_range(0, 6));
      if (!duty_if.duty_tvalid || duty_if.duty_tready) begin
        duty_if.duty_tvalid = ($urandom_range(0, 3) == 0);
        duty_if.duty_tdata  = 16'($urandom_range(0, 12));
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
